// File: rtl/arp_cache_resolver.sv
// ---------------------------------------------------------------------------
// arp_cache_resolver
//
// Resolves the next-hop MAC address for IPv4 transmit. A query from the IP
// block is first routed (null address, broadcast, on-subnet or via gateway)
// and then looked up in a small direct-mapped IP->MAC cache. On a miss the
// block asks the ARP frame generator to broadcast a request, retrying a fixed
// number of times, and waits for the ARP RX path to write the learned entry.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_query_request_*        query in (valid/ready, ip)
//   m_query_response_*       answer out (valid/ready, error, mac)
//   s_write_request_*        learned entry from ARP RX (valid/ready, ip, mac)
//   m_arp_tx_*               request to ARP frame generator (valid/ready, ip)
//   clear_cache              one-cycle pulse, invalidates every entry
//   local_ip, gateway_ip,
//   subnet_mask              configuration, sampled at the query handshake
//   busy                     high whenever the resolver is not idle
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high. A source holds valid and its payload stable until that edge; the
// sink may raise or drop ready freely. No output depends combinationally on
// any input, so ready/valid never form a combinational loop.
// ---------------------------------------------------------------------------
module arp_cache_resolver #(
   parameter int CACHE_ADDR_WIDTH = 4,
   parameter int RETRY_COUNT      = 3,
   parameter int RETRY_INTERVAL   = 125000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_query_request_valid,
   output logic        s_query_request_ready,
   input  logic [31:0] s_query_request_ip,
   output logic        m_query_response_valid,
   input  logic        m_query_response_ready,
   output logic        m_query_response_error,
   output logic [47:0] m_query_response_mac,
   input  logic        s_write_request_valid,
   output logic        s_write_request_ready,
   input  logic [31:0] s_write_request_ip,
   input  logic [47:0] s_write_request_mac,
   output logic        m_arp_tx_valid,
   input  logic        m_arp_tx_ready,
   output logic [31:0] m_arp_tx_ip,
   input  logic        clear_cache,
   input  logic [31:0] local_ip,
   input  logic [31:0] gateway_ip,
   input  logic [31:0] subnet_mask,
   output logic        busy
);

   localparam int ENTRIES = 1 << CACHE_ADDR_WIDTH;
   localparam int TW      = $clog2(RETRY_INTERVAL + 1);
   localparam int RW      = $clog2(RETRY_COUNT + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(RETRY_INTERVAL);
   localparam logic [RW-1:0] RETRY_LOAD = RW'(RETRY_COUNT);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOOKUP     = 3'd1,
      S_ARP_TX     = 3'd2,
      S_WAIT_REPLY = 3'd3,
      S_RESPOND    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                init_q;
   logic [31:0]         lookup_ip_q, lookup_ip_d;
   logic                resp_err_q, resp_err_d;
   logic [47:0]         resp_mac_q, resp_mac_d;
   logic [RW-1:0]       retries_q, retries_d;
   logic [TW-1:0]       timer_q, timer_d;

   // cache storage: valid bits are reset, payload arrays are not
   logic [ENTRIES-1:0]  valid_q;
   logic [31:0]         cache_ip_q  [ENTRIES];
   logic [47:0]         cache_mac_q [ENTRIES];

   // registered read port
   logic                rd_valid_q;
   logic [31:0]         rd_ip_q;
   logic [47:0]         rd_mac_q;

   // index folds the upper and lower halves of the address together
   function automatic logic [CACHE_ADDR_WIDTH-1:0] ip_index(input logic [31:0] ip);
      return CACHE_ADDR_WIDTH'(ip[31:16] ^ ip[15:0]);
   endfunction

   logic                          query_fire, wr_fire, tx_fire, resp_fire;
   logic                          on_subnet, is_bcast, wr_match;
   logic [31:0]                   route_ip;
   logic [CACHE_ADDR_WIDTH-1:0]   rd_idx, wr_idx;

   assign query_fire = s_query_request_valid && s_query_request_ready;
   assign wr_fire    = s_write_request_valid && init_q;
   assign tx_fire    = m_arp_tx_valid && m_arp_tx_ready;
   assign resp_fire  = m_query_response_valid && m_query_response_ready;

   // routing decision on the incoming query
   assign on_subnet = ((s_query_request_ip ^ local_ip) & subnet_mask) == 32'd0;
   assign is_bcast  = (s_query_request_ip == 32'hFFFF_FFFF) ||
                      (((s_query_request_ip & ~subnet_mask) == ~subnet_mask) && on_subnet);
   assign route_ip  = on_subnet ? s_query_request_ip : gateway_ip;

   assign rd_idx    = ip_index(route_ip);
   assign wr_idx    = ip_index(s_write_request_ip);
   assign wr_match  = wr_fire && (s_write_request_ip == lookup_ip_q);

   // ready for learned entries comes up one cycle after reset is released
   always_ff @(posedge clk) begin
      if (rst) init_q <= 1'b0;
      else     init_q <= 1'b1;
   end
   assign s_write_request_ready = init_q;

   // cache write port: clear beats a simultaneous write
   always_ff @(posedge clk) begin
      if (rst || clear_cache) begin
         valid_q <= '0;
      end else if (wr_fire) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear_cache && wr_fire) begin
         cache_ip_q[wr_idx]  <= s_write_request_ip;
         cache_mac_q[wr_idx] <= s_write_request_mac;
      end
   end

   // Read issued at the query handshake. A write or clear landing in that
   // same cycle is forwarded so the lookup never sees pre-write contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_ip_q    <= '0;
         rd_mac_q   <= '0;
      end else if (query_fire) begin
         if (clear_cache) begin
            rd_valid_q <= 1'b0;
         end else if (wr_fire && (wr_idx == rd_idx)) begin
            rd_valid_q <= 1'b1;
            rd_ip_q    <= s_write_request_ip;
            rd_mac_q   <= s_write_request_mac;
         end else begin
            rd_valid_q <= valid_q[rd_idx];
            rd_ip_q    <= cache_ip_q[rd_idx];
            rd_mac_q   <= cache_mac_q[rd_idx];
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lookup_ip_q <= '0;
         resp_err_q  <= 1'b0;
         resp_mac_q  <= '0;
         retries_q   <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         lookup_ip_q <= lookup_ip_d;
         resp_err_q  <= resp_err_d;
         resp_mac_q  <= resp_mac_d;
         retries_q   <= retries_d;
         timer_q     <= timer_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d     = state_q;
      lookup_ip_d = lookup_ip_q;
      resp_err_d  = resp_err_q;
      resp_mac_d  = resp_mac_q;
      retries_d   = retries_q;
      timer_d     = timer_q;
      unique case (state_q)
         S_IDLE: begin
            if (query_fire) begin
               lookup_ip_d = route_ip;
               resp_err_d  = 1'b0;
               resp_mac_d  = '0;
               if (s_query_request_ip == 32'd0) begin
                  resp_err_d = 1'b1;
                  state_d    = S_RESPOND;
               end else if (is_bcast) begin
                  resp_mac_d = 48'hFFFF_FFFF_FFFF;
                  state_d    = S_RESPOND;
               end else if (!on_subnet && (gateway_ip == 32'd0)) begin
                  resp_err_d = 1'b1;
                  state_d    = S_RESPOND;
               end else begin
                  state_d = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            // a learned entry arriving right now counts as a hit
            if (wr_match) begin
               resp_mac_d = s_write_request_mac;
               state_d    = S_RESPOND;
            end else if (rd_valid_q && (rd_ip_q == lookup_ip_q)) begin
               resp_mac_d = rd_mac_q;
               state_d    = S_RESPOND;
            end else begin
               retries_d = RETRY_LOAD;
               state_d   = S_ARP_TX;
            end
         end
         S_ARP_TX: begin
            if (tx_fire) begin
               retries_d = retries_q - RW'(1);
               timer_d   = TIMER_LOAD;
               state_d   = S_WAIT_REPLY;
            end
         end
         S_WAIT_REPLY: begin
            // a reply wins over a timeout in the same cycle
            if (wr_match) begin
               resp_mac_d = s_write_request_mac;
               state_d    = S_RESPOND;
            end else begin
               timer_d = timer_q - TW'(1);
               if (timer_q == TW'(1)) begin
                  if (retries_q != '0) begin
                     state_d = S_ARP_TX;
                  end else begin
                     resp_err_d = 1'b1;
                     resp_mac_d = '0;
                     state_d    = S_RESPOND;
                  end
               end
            end
         end
         S_RESPOND: begin
            if (resp_fire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      s_query_request_ready  = 1'b0;
      m_query_response_valid = 1'b0;
      m_arp_tx_valid         = 1'b0;
      busy                   = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            s_query_request_ready = init_q;
            busy                  = 1'b0;
         end
         S_ARP_TX:  m_arp_tx_valid         = 1'b1;
         S_RESPOND: m_query_response_valid = 1'b1;
         default: ;
      endcase
   end

   assign m_query_response_error = resp_err_q;
   assign m_query_response_mac   = resp_mac_q;
   assign m_arp_tx_ip            = lookup_ip_q;

endmodule

// File: tb/tb_arp_cache_resolver.sv
// ---------------------------------------------------------------------------
// tb_arp_cache_resolver
//
// Drives directed and random queries into arp_cache_resolver and compares
// each answer with a reference model: an array copy of the cache plus the
// routing rules and the retry timeline computed arithmetically.
// ---------------------------------------------------------------------------
module tb_arp_cache_resolver;

   localparam int AW       = 4;
   localparam int ENTRIES  = 1 << AW;
   localparam int RCOUNT   = 3;
   localparam int RINTERVAL = 16;
   // a retry comes back every RINTERVAL+1 edges when the generator is ready
   localparam int PERIOD   = RINTERVAL + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_query_request_valid = 1'b0;
   logic        s_query_request_ready;
   logic [31:0] s_query_request_ip = '0;
   logic        m_query_response_valid;
   logic        m_query_response_ready = 1'b0;
   logic        m_query_response_error;
   logic [47:0] m_query_response_mac;
   logic        s_write_request_valid = 1'b0;
   logic        s_write_request_ready;
   logic [31:0] s_write_request_ip = '0;
   logic [47:0] s_write_request_mac = '0;
   logic        m_arp_tx_valid;
   logic        m_arp_tx_ready = 1'b0;
   logic [31:0] m_arp_tx_ip;
   logic        clear_cache = 1'b0;
   logic [31:0] local_ip    = 32'hC0A8_0164;
   logic [31:0] gateway_ip  = 32'hC0A8_0101;
   logic [31:0] subnet_mask = 32'hFFFF_FF00;
   logic        busy;

   arp_cache_resolver #(
      .CACHE_ADDR_WIDTH(AW),
      .RETRY_COUNT     (RCOUNT),
      .RETRY_INTERVAL  (RINTERVAL)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .s_query_request_valid (s_query_request_valid),
      .s_query_request_ready (s_query_request_ready),
      .s_query_request_ip    (s_query_request_ip),
      .m_query_response_valid(m_query_response_valid),
      .m_query_response_ready(m_query_response_ready),
      .m_query_response_error(m_query_response_error),
      .m_query_response_mac  (m_query_response_mac),
      .s_write_request_valid (s_write_request_valid),
      .s_write_request_ready (s_write_request_ready),
      .s_write_request_ip    (s_write_request_ip),
      .s_write_request_mac   (s_write_request_mac),
      .m_arp_tx_valid        (m_arp_tx_valid),
      .m_arp_tx_ready        (m_arp_tx_ready),
      .m_arp_tx_ip           (m_arp_tx_ip),
      .clear_cache           (clear_cache),
      .local_ip              (local_ip),
      .gateway_ip            (gateway_ip),
      .subnet_mask           (subnet_mask),
      .busy                  (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [48:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_valid [ENTRIES];
   logic [31:0] m_ip    [ENTRIES];
   logic [47:0] m_mac   [ENTRIES];

   function automatic int model_index(input logic [31:0] ip);
      return int'(((ip >> 16) ^ (ip & 32'h0000_FFFF)) % 32'(ENTRIES));
   endfunction

   function automatic void model_write(input logic [31:0] ip, input logic [47:0] mac);
      int i;
      i = model_index(ip);
      m_valid[i] = 1'b1;
      m_ip[i]    = ip;
      m_mac[i]   = mac;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
   endfunction

   // ---------------- driver tasks ----------------
   // All tasks start and end at #1 after a rising edge.
   task automatic do_write(input logic [31:0] ip, input logic [47:0] mac,
                           input logic wr, input logic clr);
      s_write_request_valid = wr;
      s_write_request_ip    = ip;
      s_write_request_mac   = mac;
      clear_cache           = clr;
      @(posedge clk); #1;
      s_write_request_valid = 1'b0;
      clear_cache           = 1'b0;
      if (clr) model_clear();
      else if (wr) model_write(ip, mac);
   endtask

   // reply_d: edges after the first ARP tx handshake at which the learned
   // entry is written (0 = never). clr_d: same, for a clear_cache pulse.
   task automatic run_query(input logic [31:0] dest, input int reply_d,
                            input logic [47:0] reply_mac, input int tx_stall,
                            input int hold, input int clr_d);
      logic [31:0] look;
      logic        immediate, hit, same_subnet, exp_err;
      logic [47:0] exp_mac;
      logic [48:0] exp_resp;
      int          exp_tx, exp_lat, idx, k, ntx, tx0, last_tx, stall_left, budget, n;
      logic        wr_now, clr_now, tx_now, held_err;
      logic [31:0] tx_ip_seen;
      logic [47:0] held_mac;

      // expected answer from the routing rules and the cache copy
      same_subnet = (dest & subnet_mask) == (local_ip & subnet_mask);
      immediate = 1'b1; hit = 1'b0; exp_err = 1'b0; exp_mac = '0;
      exp_tx = 0; exp_lat = 1; look = dest;
      if (dest == 32'd0) begin
         exp_err = 1'b1;
      end else if (dest == 32'hFFFF_FFFF ||
                   (((dest | subnet_mask) == 32'hFFFF_FFFF) && same_subnet)) begin
         exp_mac = 48'hFFFF_FFFF_FFFF;
      end else if (!same_subnet && gateway_ip == 32'd0) begin
         exp_err = 1'b1;
      end else begin
         immediate = 1'b0;
         look = same_subnet ? dest : gateway_ip;
         idx = model_index(look);
         if (m_valid[idx] && m_ip[idx] == look) begin
            hit = 1'b1; exp_mac = m_mac[idx]; exp_lat = 2;
         end else if (reply_d > 0 && reply_d < RCOUNT * PERIOD && (reply_d % PERIOD) != 0) begin
            // reply lands inside a waiting window
            exp_mac = reply_mac;
            exp_tx  = reply_d / PERIOD + 1;
         end else begin
            // no reply, or reply landed while a request was being sent
            exp_err = 1'b1;
            exp_tx  = RCOUNT;
         end
      end
      exp_q.push_back({exp_err, exp_mac});

      // query handshake
      s_query_request_valid = 1'b1;
      s_query_request_ip    = dest;
      n = 0;
      while (!s_query_request_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check_eq("query_accept", 64'(s_query_request_ready), 64'(1));
      @(posedge clk); #1;
      s_query_request_valid = 1'b0;

      // run until the response appears
      k = 0; ntx = 0; tx0 = -1; last_tx = -1; stall_left = tx_stall;
      budget = RCOUNT * PERIOD + tx_stall + 20;
      while (!m_query_response_valid && k < budget) begin
         m_arp_tx_ready = (stall_left == 0);
         if (m_arp_tx_valid && stall_left > 0) begin
            check_eq("tx_ip_held", 64'(m_arp_tx_ip), 64'(look));
            stall_left--;
         end
         tx_now     = m_arp_tx_valid && m_arp_tx_ready;
         tx_ip_seen = m_arp_tx_ip;
         wr_now  = (tx0 >= 0) && (reply_d > 0) && (k + 1 - tx0 == reply_d);
         clr_now = (tx0 >= 0) && (clr_d > 0) && (clr_d != reply_d) && (k + 1 - tx0 == clr_d);
         s_write_request_valid = wr_now;
         s_write_request_ip    = look;
         s_write_request_mac   = reply_mac;
         clear_cache           = clr_now;
         @(posedge clk); #1; k++;
         s_write_request_valid = 1'b0;
         clear_cache           = 1'b0;
         if (clr_now) model_clear();
         if (wr_now) model_write(look, reply_mac);
         if (tx_now) begin
            ntx++;
            check_eq("tx_ip", 64'(tx_ip_seen), 64'(look));
            if (last_tx >= 0) check_eq("tx_spacing", 64'((k - last_tx) >= RINTERVAL), 64'(1));
            if (tx0 < 0) tx0 = k;
            last_tx = k;
         end
      end
      m_arp_tx_ready = 1'b0;

      exp_resp = exp_q.pop_front();
      check_eq("resp_valid", 64'(m_query_response_valid), 64'(1));
      check_eq("resp_err", 64'(m_query_response_error), 64'(exp_resp[48]));
      check_eq("resp_mac", 64'(m_query_response_mac), 64'(exp_resp[47:0]));
      check_eq("tx_count", 64'(ntx), 64'(exp_tx));
      if (immediate || hit) check_eq("resp_latency", 64'(k + 1), 64'(exp_lat));

      // backpressure on the response
      held_err = m_query_response_error;
      held_mac = m_query_response_mac;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq("hold_valid", 64'(m_query_response_valid), 64'(1));
         check_eq("hold_err", 64'(m_query_response_error), 64'(held_err));
         check_eq("hold_mac", 64'(m_query_response_mac), 64'(held_mac));
         check_eq("hold_qready", 64'(s_query_request_ready), 64'(0));
      end
      m_query_response_ready = 1'b1;
      @(posedge clk); #1;
      m_query_response_ready = 1'b0;
      check_eq("idle_after_resp", 64'(busy), 64'(0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] dest;
      int          r, n, seen;

      // reset state
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_eq("rst_qready", 64'(s_query_request_ready), 64'(0));
      check_eq("rst_wready", 64'(s_write_request_ready), 64'(0));
      check_eq("rst_resp_valid", 64'(m_query_response_valid), 64'(0));
      check_eq("rst_tx_valid", 64'(m_arp_tx_valid), 64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_mac", 64'(m_query_response_mac), 64'(0));
      model_clear();
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_qready", 64'(s_query_request_ready), 64'(1));
      check_eq("post_rst_wready", 64'(s_write_request_ready), 64'(1));

      // hit with 2-cycle latency, then backpressure on a hit
      do_write(32'hC0A8_010A, 48'h0200_0000_000A, 1'b1, 1'b0);
      run_query(32'hC0A8_010A, 0, '0, 0, 0, 0);
      run_query(32'hC0A8_010A, 0, '0, 0, 10, 0);

      // miss then reply: late reply inside the last window, early reply
      run_query(32'hC0A8_0114, 50, 48'h0200_0000_0014, 0, 0, 0);
      run_query(32'hC0A8_0115, 5, 48'h0200_0000_0015, 0, 0, 0);
      // reply lost while a retry is being sent
      run_query(32'hC0A8_0116, PERIOD, 48'h0200_0000_0016, 0, 0, 0);
      // timeout, and a generator that stalls the first request
      run_query(32'hC0A8_011E, 0, '0, 0, 0, 0);
      run_query(32'hC0A8_011F, 3, 48'h0200_0000_001F, 5, 0, 0);
      // clear during the wait does not abort the query
      run_query(32'hC0A8_0120, 8, 48'h0200_0000_0020, 0, 0, 3);

      // routing and broadcast
      run_query(32'h0A00_0005, 3, 48'h0200_0000_0101, 0, 0, 0);
      run_query(32'hC0A8_01FF, 0, '0, 0, 0, 0);
      run_query(32'hFFFF_FFFF, 0, '0, 0, 0, 0);
      run_query(32'h0000_0000, 0, '0, 0, 0, 0);
      gateway_ip = 32'd0;
      run_query(32'h0A00_0005, 0, '0, 0, 0, 0);
      gateway_ip = 32'hC0A8_0101;

      // eviction: .1 and .17 share an index
      do_write(32'hC0A8_0101, 48'h0200_0000_AA01, 1'b1, 1'b0);
      do_write(32'hC0A8_0111, 48'h0200_0000_AA11, 1'b1, 1'b0);
      run_query(32'hC0A8_0111, 0, '0, 0, 0, 0);
      run_query(32'hC0A8_0101, 4, 48'h0200_0000_BB01, 0, 0, 0);

      // clear with write in the same cycle, and a plain clear
      do_write(32'hC0A8_0128, 48'h0200_0000_0028, 1'b1, 1'b1);
      run_query(32'hC0A8_0128, 3, 48'h0200_0000_0128, 0, 0, 0);
      do_write(32'h0, 48'h0, 1'b0, 1'b1);
      run_query(32'hC0A8_010A, 2, 48'h0200_0000_010A, 0, 0, 0);

      // reset while waiting for a reply
      do_write(32'h0, 48'h0, 1'b0, 1'b1);
      s_query_request_valid = 1'b1;
      s_query_request_ip    = 32'hC0A8_014D;
      n = 0;
      while (!s_query_request_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      s_query_request_valid = 1'b0;
      n = 0;
      while (!m_arp_tx_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_eq("rstmid_tx_valid", 64'(m_arp_tx_valid), 64'(1));
      m_arp_tx_ready = 1'b1;
      @(posedge clk); #1;
      m_arp_tx_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_eq("rstmid_busy_before", 64'(busy), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      check_eq("rstmid_busy", 64'(busy), 64'(0));
      check_eq("rstmid_qready_in_rst", 64'(s_query_request_ready), 64'(0));
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (m_query_response_valid || m_arp_tx_valid) seen++;
      end
      check_eq("rstmid_no_response", 64'(seen), 64'(0));
      check_eq("rstmid_qready", 64'(s_query_request_ready), 64'(1));
      run_query(32'hC0A8_014D, 6, 48'h0200_0000_004D, 0, 0, 0);

      // random traffic
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 2))
            do_write({24'hC0A801, 8'($urandom_range(0, 31))}, {16'h0200, 32'($urandom())},
                     1'b1, ($urandom_range(0, 9) == 0));
         gateway_ip = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'hC0A8_0101;
         r = $urandom_range(0, 9);
         case (r)
            0:       dest = 32'd0;
            1:       dest = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'hC0A8_01FF;
            2, 3:    dest = {8'd10, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(1, 254))};
            default: dest = {24'hC0A801, 8'($urandom_range(0, 31))};
         endcase
         run_query(dest, $urandom_range(0, 60), {16'h0200, 32'($urandom())},
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 40));
      end
      gateway_ip = 32'hC0A8_0101;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
